// File: rtl/spi_poll_master_if.sv
// rtl/spi_poll_master_if.sv - Handshake, data and SPI pin bundle for spi_poll_master
interface spi_poll_master_if #(
  parameter int FRAME_BITS = 40
);
  logic                  start;
  logic                  poll_en;
  logic [FRAME_BITS-1:0] tx_data;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  cs;
  logic                  sck;
  logic                  mosi;
  logic                  miso;

  modport master (
    input  start, poll_en, tx_data, miso,
    output rx_data, rx_valid, busy, cs, sck, mosi
  );

  modport slave (
    output start, poll_en, tx_data, miso,
    input  rx_data, rx_valid, busy, cs, sck, mosi
  );
endinterface

// File: rtl/spi_poll_master.sv
// rtl/spi_poll_master.sv - Configurable-width SPI master with start/busy/done handshake and auto-poll
module spi_poll_master #(
  parameter int FRAME_BITS = 40,
  parameter int CLK_DIV    = 25,
  parameter int CS_SETUP   = 750,
  parameter int BYTE_GAP   = 500,
  parameter int FRAME_GAP  = 0,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0
) (
  input  logic               clk50M,
  input  logic               rst_n,
  spi_poll_master_if.master  bus
);

  // One shared delay counter serves SETUP, SHIFT half-periods, BGAP, HOLD and FGAP.
  localparam int M1  = (CS_SETUP > BYTE_GAP) ? CS_SETUP : BYTE_GAP;
  localparam int M2  = (FRAME_GAP > CLK_DIV) ? FRAME_GAP : CLK_DIV;
  localparam int MAXD = (M1 > M2) ? M1 : M2;
  localparam int CW  = $clog2(MAXD + 1);
  localparam int BW  = $clog2(FRAME_BITS + 1);

  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] BGAP_LAST  = CW'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);
  localparam logic [CW-1:0] FGAP_LAST  = CW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);
  localparam logic [BW-1:0] LAST_BIT   = BW'(FRAME_BITS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, BGAP, HOLD, FGAP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [BW-1:0]         bit_nxt;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  cs_q, cs_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;

  // State and datapath registers; reset abandons any frame without a done pulse.
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cs_q       <= 1'b1;
      sck_q      <= CPOL;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
    end
  end

  // Next-state and output logic; a tick in SHIFT is a leading edge while sck still sits at CPOL.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    cs_d       = cs_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    bit_nxt    = bit_q + 1'b1;

    case (state_q)
      IDLE: begin
        cs_d  = 1'b1;
        sck_d = CPOL;
        cnt_d = '0;
        if (bus.start || bus.poll_en) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          bit_d   = '0;
          if (CPHA == 1'b0) begin
            // MSB sits on mosi for the whole setup window.
            mosi_d = bus.tx_data[FRAME_BITS-1];
            tx_d   = {bus.tx_data[FRAME_BITS-2:0], 1'b0};
          end else begin
            tx_d   = bus.tx_data;
          end
        end
      end

      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          if (sck_q == CPOL) begin
            if (CPHA == 1'b0) begin
              rx_d = {rx_q[FRAME_BITS-2:0], bus.miso};
            end else begin
              mosi_d = tx_q[FRAME_BITS-1];
              tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
            end
          end else begin
            bit_d = bit_nxt;
            if (CPHA == 1'b1) begin
              rx_d = {rx_q[FRAME_BITS-2:0], bus.miso};
            end else if (bit_q != LAST_BIT) begin
              mosi_d = tx_q[FRAME_BITS-1];
              tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
            end
            if (bit_q == LAST_BIT) begin
              state_d = HOLD;
            end else if ((BYTE_GAP > 0) && ((int'(bit_nxt) % 8) == 0)) begin
              state_d = BGAP;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      BGAP: begin
        if (cnt_q == BGAP_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d      = '0;
          cs_d       = 1'b1;
          rx_data_d  = rx_q;
          rx_valid_d = 1'b1;
          // Auto-poll restarts through IDLE, which re-latches tx_data one cycle later.
          state_d    = (FRAME_GAP > 0) ? FGAP : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      FGAP: begin
        if (cnt_q == FGAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.cs       = cs_q;
  assign bus.sck      = sck_q;
  assign bus.mosi     = mosi_q;

endmodule

// File: tb/tb_spi_poll_master.sv
// tb/tb_spi_poll_master.sv - Directed self-checking bench for spi_poll_master
module tb_spi_poll_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Instances 0..3: 16-bit frames in SPI modes 0..3; instance 4: mode 0 with 4-cycle byte gaps.
  logic        start_a [5];
  logic        poll_a  [5];
  logic [15:0] tx_a    [5];
  logic [15:0] sword_a [5];
  wire  [15:0] rxd_a   [5];
  wire  [15:0] mcap_a  [5];
  wire         rxv_a   [5];
  wire         busy_a  [5];
  wire         cs_a    [5];
  wire         sck_a   [5];
  wire         mosi_a  [5];
  wire  [31:0] nv_a    [5];

  for (genvar m = 0; m < 5; m++) begin : g_dut
    localparam bit CP = ((m / 2) % 2) == 1;
    localparam bit CH = (m % 2) == 1;
    localparam int BG = (m == 4) ? 4 : 0;

    spi_poll_master_if #(.FRAME_BITS(16)) ifm ();

    spi_poll_master #(
      .FRAME_BITS(16), .CLK_DIV(2), .CS_SETUP(3), .BYTE_GAP(BG),
      .FRAME_GAP(2), .CPOL(CP), .CPHA(CH)
    ) dut (
      .clk50M(clk),
      .rst_n (rst_n),
      .bus   (ifm)
    );

    logic        miso_r   = 1'b0;
    logic        prev_sck = CP;
    int          idx      = 0;
    logic [15:0] mcap     = '0;
    int          nv       = 0;

    assign ifm.start   = start_a[m];
    assign ifm.poll_en = poll_a[m];
    assign ifm.tx_data = tx_a[m];
    assign ifm.miso    = miso_r;
    assign rxd_a[m]    = ifm.rx_data;
    assign rxv_a[m]    = ifm.rx_valid;
    assign busy_a[m]   = ifm.busy;
    assign cs_a[m]     = ifm.cs;
    assign sck_a[m]    = ifm.sck;
    assign mosi_a[m]   = ifm.mosi;
    assign mcap_a[m]   = mcap;
    assign nv_a[m]     = nv;

    // Slave model: drives its word MSB-first and captures mosi on the edges its mode defines.
    always @(negedge clk) begin
      if (cs_a[m]) begin
        idx      <= 0;
        miso_r   <= CH ? 1'b0 : sword_a[m][15];
        prev_sck <= sck_a[m];
      end else if (sck_a[m] != prev_sck) begin
        prev_sck <= sck_a[m];
        if (sck_a[m] != CP) begin
          if (!CH) mcap <= {mcap[14:0], mosi_a[m]};
          else     miso_r <= sword_a[m][15-idx];
        end else begin
          if (CH) mcap <= {mcap[14:0], mosi_a[m]};
          idx <= idx + 1;
          if (!CH && idx < 15) miso_r <= sword_a[m][14-idx];
        end
      end
      if (rxv_a[m]) nv <= nv + 1;
    end
  end

  // Joystick-sized instance with the default parameters.
  spi_poll_master_if #(.FRAME_BITS(40)) ifj ();

  spi_poll_master u_js (
    .clk50M(clk),
    .rst_n (rst_n),
    .bus   (ifj)
  );

  logic        js_start = 1'b0;
  logic [39:0] js_word;
  logic        js_miso = 1'b0;
  logic        js_prev_sck = 1'b0;
  logic        js_prev_cs = 1'b1;
  int          js_idx = 0;
  int          js_fall = 0;
  int          js_ecount = 0;
  int          ecyc [80];
  logic [39:0] js_mcap = '0;

  assign ifj.start   = js_start;
  assign ifj.poll_en = 1'b0;
  assign ifj.tx_data = 40'h8300000000;
  assign ifj.miso    = js_miso;

  // PmodJSTK model: returns X lo/hi, Y lo/hi, buttons and logs each sck edge cycle.
  always @(negedge clk) begin
    js_prev_cs <= ifj.cs;
    if (js_prev_cs && !ifj.cs) begin
      js_fall   <= cyc;
      js_ecount <= 0;
    end
    if (ifj.cs) begin
      js_idx      <= 0;
      js_miso     <= js_word[39];
      js_prev_sck <= ifj.sck;
    end else if (ifj.sck != js_prev_sck) begin
      js_prev_sck <= ifj.sck;
      if (js_ecount < 80) ecyc[js_ecount] <= cyc;
      js_ecount <= js_ecount + 1;
      if (ifj.sck) begin
        js_mcap <= {js_mcap[38:0], ifj.mosi};
      end else begin
        js_idx <= js_idx + 1;
        if (js_idx < 39) js_miso <= js_word[38-js_idx];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: cycle %0d reached, simulation limit", cyc);
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    for (int m = 0; m < 5; m++) begin
      logic cp;
      cp = (m == 2 || m == 3);
      checks++; if (cs_a[m] !== 1'b1) begin errors++; $display("FAIL reset_cs m=%0d: got %b want 1", m, cs_a[m]); end
      checks++; if (sck_a[m] !== cp) begin errors++; $display("FAIL reset_sck m=%0d: got %b want %b", m, sck_a[m], cp); end
      checks++; if (busy_a[m] !== 1'b0) begin errors++; $display("FAIL reset_busy m=%0d: got %b want 0", m, busy_a[m]); end
      checks++; if (rxv_a[m] !== 1'b0) begin errors++; $display("FAIL reset_rxv m=%0d: got %b want 0", m, rxv_a[m]); end
      checks++; if (rxd_a[m] !== 16'h0000) begin errors++; $display("FAIL reset_rxd m=%0d: got %h want 0000", m, rxd_a[m]); end
      checks++; if (mosi_a[m] !== 1'b0) begin errors++; $display("FAIL reset_mosi m=%0d: got %b want 0", m, mosi_a[m]); end
    end
    checks++; if (ifj.cs !== 1'b1 || ifj.busy !== 1'b0) begin errors++; $display("FAIL reset_js: got cs=%b busy=%b want cs=1 busy=0", ifj.cs, ifj.busy); end
  endtask

  task automatic test_modes();
    for (int m = 0; m < 4; m++) begin
      logic cp;
      int   e0, tv;
      cp = (m == 2 || m == 3);
      checks++; if (sck_a[m] !== cp) begin errors++; $display("FAIL idle_sck m=%0d: got %b want %b", m, sck_a[m], cp); end
      @(negedge clk); tx_a[m] = 16'hA5C3; sword_a[m] = 16'h3C5A;
      @(negedge clk); start_a[m] = 1'b1; e0 = cyc + 1;
      @(negedge clk); start_a[m] = 1'b0;
      tv = -1;
      for (int i = 0; i < 200; i++) begin
        if (rxv_a[m]) begin tv = cyc; break; end
        @(negedge clk);
      end
      checks++; if (tv - e0 != 69) begin errors++; $display("FAIL mode_latency m=%0d: got %0d want 69", m, tv - e0); end
      checks++; if (rxd_a[m] !== 16'h3C5A) begin errors++; $display("FAIL mode_rxd m=%0d: got %h want 3c5a", m, rxd_a[m]); end
      checks++; if (mcap_a[m] !== 16'hA5C3) begin errors++; $display("FAIL mode_mosi m=%0d: got %h want a5c3", m, mcap_a[m]); end
      @(negedge clk);
      checks++; if (rxv_a[m] !== 1'b0) begin errors++; $display("FAIL mode_rxv_width m=%0d: got %b want 0", m, rxv_a[m]); end
      checks++; if (busy_a[m] !== 1'b1) begin errors++; $display("FAIL mode_busy_fgap m=%0d: got %b want 1", m, busy_a[m]); end
      @(negedge clk);
      checks++; if (busy_a[m] !== 1'b0) begin errors++; $display("FAIL mode_busy_fall m=%0d: got %b want 0", m, busy_a[m]); end
      checks++; if (sck_a[m] !== cp) begin errors++; $display("FAIL mode_sck_end m=%0d: got %b want %b", m, sck_a[m], cp); end
    end
  endtask

  task automatic test_joystick();
    int e0, tv;
    @(negedge clk); js_start = 1'b1; e0 = cyc + 1;
    @(negedge clk); js_start = 1'b0;
    tv = -1;
    for (int i = 0; i < 6000; i++) begin
      if (ifj.rx_valid) begin tv = cyc; break; end
      @(negedge clk);
    end
    checks++; if (tv - e0 != 4775) begin errors++; $display("FAIL js_latency: got %0d want 4775", tv - e0); end
    checks++; if (ifj.rx_data !== 40'hF301A20002) begin errors++; $display("FAIL js_rxd: got %h want f301a20002", ifj.rx_data); end
    checks++; if (js_mcap !== 40'h8300000000) begin errors++; $display("FAIL js_mosi: got %h want 8300000000", js_mcap); end
    checks++; if (js_fall != e0) begin errors++; $display("FAIL js_cs_fall: got %0d want %0d", js_fall, e0); end
    checks++; if (js_ecount != 80) begin errors++; $display("FAIL js_edges: got %0d want 80", js_ecount); end
    checks++; if (ecyc[0] - js_fall != 775) begin errors++; $display("FAIL js_setup: got %0d want 775", ecyc[0] - js_fall); end
    checks++; if (ecyc[1] - ecyc[0] != 25) begin errors++; $display("FAIL js_half: got %0d want 25", ecyc[1] - ecyc[0]); end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (ecyc[16*k] - ecyc[16*k-1] != 525) begin
        errors++; $display("FAIL js_byte_gap k=%0d: got %0d want 525", k, ecyc[16*k] - ecyc[16*k-1]);
      end
    end
  endtask

  task automatic test_auto_poll();
    int e0, tv, prev, base;
    base = nv_a[4];
    @(negedge clk); tx_a[4] = 16'h1234; sword_a[4] = 16'hBEEF;
    @(negedge clk); poll_a[4] = 1'b1; e0 = cyc + 1;
    prev = e0;
    for (int f = 0; f < 4; f++) begin
      tv = -1;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (rxv_a[4]) begin tv = cyc; break; end
      end
      checks++;
      if (tv - prev != ((f == 0) ? 73 : 76)) begin
        errors++; $display("FAIL poll_spacing f=%0d: got %0d want %0d", f, tv - prev, (f == 0) ? 73 : 76);
      end
      checks++; if (rxd_a[4] !== 16'hBEEF) begin errors++; $display("FAIL poll_rxd f=%0d: got %h want beef", f, rxd_a[4]); end
      checks++; if (mcap_a[4] !== 16'h1234) begin errors++; $display("FAIL poll_mosi f=%0d: got %h want 1234", f, mcap_a[4]); end
      prev = tv;
      if (f == 2) begin
        repeat (20) @(negedge clk);
        poll_a[4] = 1'b0;
      end
    end
    repeat (200) @(negedge clk);
    checks++; if (nv_a[4] - base != 4) begin errors++; $display("FAIL poll_count: got %0d want 4", nv_a[4] - base); end
    checks++; if (busy_a[4] !== 1'b0) begin errors++; $display("FAIL poll_busy_end: got %b want 0", busy_a[4]); end
  endtask

  task automatic test_ignored_start();
    int e0, tv, base;
    base = nv_a[0];
    @(negedge clk); tx_a[0] = 16'hC0DE; sword_a[0] = 16'h1357;
    @(negedge clk); start_a[0] = 1'b1; e0 = cyc + 1;
    @(negedge clk); start_a[0] = 1'b0;
    while (cyc < e0 + 20) @(negedge clk);
    start_a[0] = 1'b1; tx_a[0] = 16'hFFFF;
    @(negedge clk); start_a[0] = 1'b0;
    tv = -1;
    for (int i = 0; i < 200; i++) begin
      if (rxv_a[0]) begin tv = cyc; break; end
      @(negedge clk);
    end
    checks++; if (tv - e0 != 69) begin errors++; $display("FAIL ign_latency: got %0d want 69", tv - e0); end
    checks++; if (mcap_a[0] !== 16'hC0DE) begin errors++; $display("FAIL ign_mosi: got %h want c0de", mcap_a[0]); end
    checks++; if (rxd_a[0] !== 16'h1357) begin errors++; $display("FAIL ign_rxd: got %h want 1357", rxd_a[0]); end
    repeat (150) @(negedge clk);
    checks++; if (nv_a[0] - base != 1) begin errors++; $display("FAIL ign_count: got %0d want 1", nv_a[0] - base); end
    checks++; if (busy_a[0] !== 1'b0) begin errors++; $display("FAIL ign_busy: got %b want 0", busy_a[0]); end
  endtask

  task automatic test_reset_mid();
    int e0, tv, base;
    base = nv_a[4];
    @(negedge clk); tx_a[4] = 16'h5555; sword_a[4] = 16'hAAAA;
    @(negedge clk); start_a[4] = 1'b1; e0 = cyc + 1;
    @(negedge clk); start_a[4] = 1'b0;
    while (cyc < e0 + 36) @(negedge clk);
    checks++; if (cs_a[4] !== 1'b0 || sck_a[4] !== 1'b0) begin errors++; $display("FAIL rst_pre_bgap: got cs=%b sck=%b want cs=0 sck=0", cs_a[4], sck_a[4]); end
    rst_n = 1'b0;
    #1;
    checks++; if (cs_a[4] !== 1'b1) begin errors++; $display("FAIL rst_cs: got %b want 1", cs_a[4]); end
    checks++; if (sck_a[4] !== 1'b0) begin errors++; $display("FAIL rst_sck: got %b want 0", sck_a[4]); end
    checks++; if (busy_a[4] !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_a[4]); end
    checks++; if (rxd_a[4] !== 16'h0000) begin errors++; $display("FAIL rst_rxd: got %h want 0000", rxd_a[4]); end
    checks++; if (rxv_a[4] !== 1'b0) begin errors++; $display("FAIL rst_rxv: got %b want 0", rxv_a[4]); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (nv_a[4] != base) begin errors++; $display("FAIL rst_no_valid: got %0d want %0d", nv_a[4], base); end
    tx_a[4] = 16'h0F0F; sword_a[4] = 16'hF00F;
    @(negedge clk); start_a[4] = 1'b1; e0 = cyc + 1;
    @(negedge clk); start_a[4] = 1'b0;
    tv = -1;
    for (int i = 0; i < 200; i++) begin
      if (rxv_a[4]) begin tv = cyc; break; end
      @(negedge clk);
    end
    checks++; if (tv - e0 != 73) begin errors++; $display("FAIL rst_fresh_latency: got %0d want 73", tv - e0); end
    checks++; if (rxd_a[4] !== 16'hF00F) begin errors++; $display("FAIL rst_fresh_rxd: got %h want f00f", rxd_a[4]); end
    checks++; if (mcap_a[4] !== 16'h0F0F) begin errors++; $display("FAIL rst_fresh_mosi: got %h want 0f0f", mcap_a[4]); end
  endtask

  initial begin
    rst_n   = 1'b0;
    js_word = 40'hF301A20002;
    for (int m = 0; m < 5; m++) begin
      start_a[m] = 1'b0; poll_a[m] = 1'b0; tx_a[m] = '0; sword_a[m] = '0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_modes();
    test_joystick();
    test_auto_poll();
    test_ignored_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
